calc_sequencer: RTL

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - collects two operand bytes and an op, launches the external ALU, captures its result
// Optional divide-by-zero guard is compiled in with `define DIV0_CHECK_EN.
module calc_sequencer #(
  parameter int TIMEOUT_CYC = 3000,
  parameter int ALU_LAT     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        done1,
  input  logic [7:0]  rdata1,
  input  logic        done2,
  input  logic [7:0]  rdata2,
  input  logic        add,
  input  logic        sub,
  input  logic        mult,
  input  logic        div,
  input  logic [31:0] alu_result,
  output logic [7:0]  data1,
  output logic [7:0]  data2,
  output logic [2:0]  alu_sel,
  output logic        start,
  output logic [31:0] result,
  output logic        res_valid,
  output logic        busy,
  output logic        timeout,
  output logic        err
);
  localparam int            CW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]    LAT_LAST  = 4'(ALU_LAT);
  localparam logic [2:0]    SEL_ADD   = 3'b000;
  localparam logic [2:0]    SEL_SUB   = 3'b001;
  localparam logic [2:0]    SEL_MUL   = 3'b010;
  localparam logic [2:0]    SEL_DIV   = 3'b100;
  localparam logic [2:0]    SEL_NONE  = 3'b101;

  typedef enum logic [1:0] {COLLECT, ARMED, EXEC, DONE} state_t;

  state_t        state, state_nxt;
  logic [7:0]    data1_nxt, data2_nxt;
  logic          a_vld, a_vld_nxt, b_vld, b_vld_nxt, op_pend, op_pend_nxt;
  logic [2:0]    alu_sel_nxt, op_code;
  logic [31:0]   result_nxt;
  logic          res_valid_nxt, start_nxt, timeout_nxt, err_q, err_nxt;
  logic [3:0]    lat_cnt, lat_cnt_nxt;
  logic [CW-1:0] idle_cnt, idle_cnt_nxt;
  logic          byte_in, op_in, go_exec, flush;

  always_comb begin
    state_nxt     = state;
    data1_nxt     = data1;
    data2_nxt     = data2;
    a_vld_nxt     = a_vld;
    b_vld_nxt     = b_vld;
    op_pend_nxt   = op_pend;
    alu_sel_nxt   = alu_sel;
    result_nxt    = result;
    res_valid_nxt = res_valid;
    lat_cnt_nxt   = lat_cnt;
    idle_cnt_nxt  = idle_cnt;
    start_nxt     = 1'b0;
    timeout_nxt   = 1'b0;
    err_nxt       = err_q;
    go_exec       = 1'b0;
    flush         = 1'b0;
    byte_in       = done1 | done2;
    op_in         = add | sub | mult | div;
    op_code       = SEL_DIV;
    if (add)       op_code = SEL_ADD;
    else if (sub)  op_code = SEL_SUB;
    else if (mult) op_code = SEL_MUL;

    // Inputs are only accepted outside EXEC; anything arriving during EXEC is dropped.
    if (state != EXEC) begin
      if (done1) begin
        data1_nxt = rdata1;
        a_vld_nxt = 1'b1;
      end
      if (done2) begin
        data2_nxt = rdata2;
        b_vld_nxt = 1'b1;
      end
      if (op_in) begin
        op_pend_nxt = 1'b1;
        alu_sel_nxt = op_code;
      end
      if (byte_in)                     idle_cnt_nxt = '0;
      else if (idle_cnt == IDLE_LAST)  flush = 1'b1;
      else                             idle_cnt_nxt = idle_cnt + CW'(1);
    end

    case (state)
      COLLECT: if (a_vld && b_vld) state_nxt = ARMED;
      ARMED:   if (op_pend) go_exec = 1'b1;
      EXEC: begin
        if (lat_cnt == LAT_LAST) begin
          result_nxt    = alu_result;
          res_valid_nxt = 1'b1;
          state_nxt     = DONE;
        end else begin
          lat_cnt_nxt = lat_cnt + 4'd1;
        end
      end
      DONE: begin
        if (byte_in || op_in) begin
          go_exec       = 1'b1;
          res_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = COLLECT;
    endcase

    if (go_exec) begin
      state_nxt   = EXEC;
      lat_cnt_nxt = '0;
      start_nxt   = 1'b1;
      err_nxt     = 1'b0;
`ifdef DIV0_CHECK_EN
      // Judged on the operands EXEC would actually hold, including this cycle's update.
      if (alu_sel_nxt == SEL_DIV && data2_nxt == 8'd0) begin
        state_nxt     = DONE;
        start_nxt     = 1'b0;
        err_nxt       = 1'b1;
        result_nxt    = '0;
        res_valid_nxt = 1'b0;
      end
`endif
    end

    if (flush) begin
      state_nxt     = COLLECT;
      data1_nxt     = '0;
      data2_nxt     = '0;
      a_vld_nxt     = 1'b0;
      b_vld_nxt     = 1'b0;
      op_pend_nxt   = 1'b0;
      alu_sel_nxt   = SEL_NONE;
      result_nxt    = '0;
      res_valid_nxt = 1'b0;
      start_nxt     = 1'b0;
      timeout_nxt   = 1'b1;
      err_nxt       = 1'b0;
      idle_cnt_nxt  = '0;
    end
`ifndef DIV0_CHECK_EN
    err_nxt = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= COLLECT;
      data1     <= '0;
      data2     <= '0;
      a_vld     <= 1'b0;
      b_vld     <= 1'b0;
      op_pend   <= 1'b0;
      alu_sel   <= SEL_NONE;
      result    <= '0;
      res_valid <= 1'b0;
      start     <= 1'b0;
      timeout   <= 1'b0;
      err_q     <= 1'b0;
      lat_cnt   <= '0;
      idle_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      data1     <= data1_nxt;
      data2     <= data2_nxt;
      a_vld     <= a_vld_nxt;
      b_vld     <= b_vld_nxt;
      op_pend   <= op_pend_nxt;
      alu_sel   <= alu_sel_nxt;
      result    <= result_nxt;
      res_valid <= res_valid_nxt;
      start     <= start_nxt;
      timeout   <= timeout_nxt;
      err_q     <= err_nxt;
      lat_cnt   <= lat_cnt_nxt;
      idle_cnt  <= idle_cnt_nxt;
    end
  end

  assign busy = (state == EXEC);
  assign err  = err_q;

endmodule
